// File: rtl/iar_fetch_stepper_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// iar_fetch_stepper_pkg : step codes, one-hot states, strobe bit map
// Rev 1.0
// ------------------------------------------------------------------
package iar_fetch_stepper_pkg;

  localparam logic [2:0] STEP_IDLE = 3'd0;
  localparam logic [2:0] STEP_1    = 3'd1;
  localparam logic [2:0] STEP_2    = 3'd2;
  localparam logic [2:0] STEP_3    = 3'd3;
  localparam logic [2:0] STEP_4    = 3'd4;
  localparam logic [2:0] STEP_5    = 3'd5;
  localparam logic [2:0] STEP_6    = 3'd6;
  localparam logic [2:0] STEP_7    = 3'd7;

  localparam logic [7:0] OH_IDLE = 8'b0000_0001;
  localparam logic [7:0] OH_S1   = 8'b0000_0010;
  localparam logic [7:0] OH_S2   = 8'b0000_0100;
  localparam logic [7:0] OH_S3   = 8'b0000_1000;
  localparam logic [7:0] OH_S4   = 8'b0001_0000;
  localparam logic [7:0] OH_S5   = 8'b0010_0000;
  localparam logic [7:0] OH_S6   = 8'b0100_0000;
  localparam logic [7:0] OH_S7   = 8'b1000_0000;

  typedef enum logic [7:0] {
    ST_IDLE = OH_IDLE,
    ST_S1   = OH_S1,
    ST_S2   = OH_S2,
    ST_S3   = OH_S3,
    ST_S4   = OH_S4,
    ST_S5   = OH_S5,
    ST_S6   = OH_S6,
    ST_S7   = OH_S7
  } state_t;

  // Strobe vector layout, shared with the instruction decoder
  localparam int STB_IAR_E = 0;
  localparam int STB_IAR_S = 1;
  localparam int STB_MAR_S = 2;
  localparam int STB_BUS1  = 3;
  localparam int STB_ACC_S = 4;
  localparam int STB_ACC_E = 5;
  localparam int STB_RAM_E = 6;
  localparam int STB_IR_S  = 7;
  localparam int STB_W     = 8;

  function automatic logic [2:0] state_to_step(state_t s);
    case (s)
      ST_S1:   return STEP_1;
      ST_S2:   return STEP_2;
      ST_S3:   return STEP_3;
      ST_S4:   return STEP_4;
      ST_S5:   return STEP_5;
      ST_S6:   return STEP_6;
      ST_S7:   return STEP_7;
      default: return STEP_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/iar_fetch_stepper_if.sv
`default_nettype none
// ------------------------------------------------------------------
// iar_fetch_stepper_if : sequencer control inputs and fetch strobes
// Rev 1.0
// ------------------------------------------------------------------
interface iar_fetch_stepper_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             halt;
  logic             mem_ready;
  logic             exec_done;
  logic [2:0]       step;
  logic             iar_rst;
  logic             iar_e;
  logic             iar_s;
  logic             mar_s;
  logic             bus1;
  logic             acc_s;
  logic             acc_e;
  logic             ram_e;
  logic             ir_s;
  logic [CNT_W-1:0] instr_cnt;
  logic             err;

  modport master (
    input  run, halt, mem_ready, exec_done,
    output step, iar_rst, iar_e, iar_s, mar_s, bus1, acc_s, acc_e, ram_e, ir_s,
           instr_cnt, err
  );

  modport slave (
    output run, halt, mem_ready, exec_done,
    input  step, iar_rst, iar_e, iar_s, mar_s, bus1, acc_s, acc_e, ram_e, ir_s,
           instr_cnt, err
  );
endinterface
`default_nettype wire

// File: rtl/iar_wait_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// iar_wait_timer : loadable down-counter with terminal flag
// Rev 1.0
// ------------------------------------------------------------------
module iar_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic terminal
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  // Loaded with TIMEOUT-1 so terminal rises on the TIMEOUT-th waiting cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMEOUT - 1);
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule
`default_nettype wire

// File: rtl/iar_fetch_stepper.sv
`default_nettype none
// ------------------------------------------------------------------
// iar_fetch_stepper : seven-step IAR fetch/execute sequencer
// Rev 1.0
// ------------------------------------------------------------------
module iar_fetch_stepper
  import iar_fetch_stepper_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  iar_fetch_stepper_if.master ctl
);

  state_t             state;
  state_t             state_nx;
  logic               rst_meta;
  logic               iar_rst;
  logic               err;
  logic               set_err;
  logic               instr_end;
  logic               timer_load;
  logic               timer_dec;
  logic               wait_expired;
  logic [CNT_W-1:0]   retired;
  logic [STB_W-1:0]   strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b1;
      iar_rst  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      iar_rst  <= rst_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      err     <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (set_err) begin
        err <= 1'b1;
      end
      if (instr_end) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    instr_end = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctl.run && !ctl.halt && !err && !iar_rst) begin
          state_nx = ST_S1;
        end
      end
      ST_S1: state_nx = ST_S2;
      ST_S2: begin
        if (ctl.mem_ready) begin
          state_nx = ST_S3;
        end else if (wait_expired) begin
          set_err  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_S3: state_nx = ST_S4;
      ST_S4: if (ctl.exec_done) instr_end = 1'b1; else state_nx = ST_S5;
      ST_S5: if (ctl.exec_done) instr_end = 1'b1; else state_nx = ST_S6;
      ST_S6: if (ctl.exec_done) instr_end = 1'b1; else state_nx = ST_S7;
      ST_S7: instr_end = 1'b1;
      default: state_nx = ST_IDLE;
    endcase
    // Run/halt only matter at the instruction boundary
    if (instr_end) begin
      state_nx = (ctl.run && !ctl.halt) ? ST_S1 : ST_IDLE;
    end
  end

  assign timer_load = (state == ST_S1);
  assign timer_dec  = (state == ST_S2) && !ctl.mem_ready;

  iar_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .dec      (timer_dec),
    .terminal (wait_expired)
  );

  always_comb begin
    strobe = '0;
    case (state)
      ST_S1: begin
        strobe[STB_IAR_E] = 1'b1;
        strobe[STB_BUS1]  = 1'b1;
        strobe[STB_MAR_S] = 1'b1;
        strobe[STB_ACC_S] = 1'b1;
      end
      ST_S2: begin
        strobe[STB_RAM_E] = 1'b1;
        strobe[STB_IR_S]  = 1'b1;
      end
      ST_S3: begin
        strobe[STB_ACC_E] = 1'b1;
        strobe[STB_IAR_S] = 1'b1;
      end
      default: strobe = '0;
    endcase
  end

  assign ctl.step      = state_to_step(state);
  assign ctl.iar_rst   = iar_rst;
  assign ctl.iar_e     = strobe[STB_IAR_E];
  assign ctl.iar_s     = strobe[STB_IAR_S];
  assign ctl.mar_s     = strobe[STB_MAR_S];
  assign ctl.bus1      = strobe[STB_BUS1];
  assign ctl.acc_s     = strobe[STB_ACC_S];
  assign ctl.acc_e     = strobe[STB_ACC_E];
  assign ctl.ram_e     = strobe[STB_RAM_E];
  assign ctl.ir_s      = strobe[STB_IR_S];
  assign ctl.instr_cnt = retired;
  assign ctl.err       = err;

endmodule
`default_nettype wire

// File: doc/iar_fetch_stepper.md
# iar_fetch_stepper

Seven-step sequencer for the instruction fetch/execute cycle around the Instruction Address Register. Owns steps 1–3 outright and drives IAR enable/set, MAR set, BUS1, ACC set/enable, RAM enable and IR set. Exposes the current step to the instruction decoder for steps 4–7. Also adds a memory-ready wait with timeout, early end-of-instruction, halt at instruction boundaries, and a retired-instruction counter.

## Interface
Parameters:
- TIMEOUT, 16, max cycles step 2 waits for mem_ready before error
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; permits leaving IDLE and continuing past instruction end
- halt  in  1  level; stop at next instruction boundary
- mem_ready  in  1  RAM data valid on bus, sampled in step 2
- exec_done  in  1  decoder: current instruction finished, valid in steps 4–6
- step  out  3  0 = IDLE, 1..7 = active step
- iar_rst  out  1  reset to IAR
- iar_e, iar_s, mar_s, bus1, acc_s, acc_e, ram_e, ir_s  out  1 each  fetch control strobes
- instr_cnt  out  CNT_W  retired instructions
- err  out  1  sticky memory timeout flag

## Operation
States: IDLE, S1..S7, one-hot internally; step output encodes the state.

Control strobes are Moore decodes of the state. All strobes are 0 outside the listed steps.
- S1: iar_e, bus1, mar_s, acc_s = 1. MAR ← IAR; ACC ← IAR+1.
- S2: ram_e, ir_s = 1. IR ← RAM[MAR].
- S3: acc_e, iar_s = 1. IAR ← ACC.
- S4–S7: all strobes 0; the decoder owns the bus.

Transitions:
- IDLE → S1 when run=1, halt=0, err=0.
- S1 → S2.
- S2 → S3 when mem_ready=1; otherwise hold.
- S2 timeout: if the wait counter reaches TIMEOUT-1 with mem_ready=0, set err=1 and go to IDLE. No IAR update happens.
- S3 → S4.
- S4..S6 → next step if exec_done=0; instruction end if exec_done=1.
- S7 → instruction end unconditionally.
- Instruction end: instr_cnt += 1 (wraps modulo 2^CNT_W). Then go to S1 if run=1 and halt=0, else IDLE.

Halt and run are examined only at instruction end or in IDLE. Asserting them mid-instruction never truncates it.

err is sticky and blocks IDLE exit. It clears only on reset.

Wait counter:
- Cleared on S2 entry.
- Increments each S2 cycle with mem_ready=0.
- Width is clog2(TIMEOUT).

exec_done is ignored outside S4–S6.

## Timing
- Reset values: step=0 (IDLE), all strobes=0, instr_cnt=0, err=0, iar_rst=1.
- iar_rst: asserted asynchronously with reset_n low. Deasserted on the second rising edge after reset_n rises (2-flop synchronised release). IDLE exit is blocked while iar_rst=1.
- State advances once per clk; strobes change only after a rising edge (no glitches from inputs).
- Minimum instruction is 4 cycles (S1–S4 with exec_done in S4); maximum without wait is 7.
- A back-to-back instruction enters S1 in the cycle immediately after the last step, with no IDLE bubble.
- mem_ready sampled on the same edge that leaves S2; zero-wait memory gives exactly one S2 cycle.
- instr_cnt updates on the edge leaving the final step.
- Reset mid-instruction forces IDLE immediately and asynchronously; partial fetch effects are discarded.
- run, halt, mem_ready and exec_done are synchronous to clk.

## Structure
- Shared package/include holds:
  - step encodings (STEP_IDLE=0 … STEP_7=7);
  - the one-hot state localparams;
  - the strobe-vector bit positions, also used by the decoder.
- One natural sub-module, iar_wait_timer: loadable down-counter with a terminal flag, used for the S2 timeout.
- Everything else is a flat FSM plus output decode.

## Test plan
- Reset then run=1, mem_ready=1, exec_done=0: step sequence 1,2,3,4,5,6,7,1. Strobes match the per-step list. instr_cnt=1 after the first S7.
- exec_done=1 in S4 for 3 instructions: each instruction is 4 cycles; instr_cnt=3 after 12 cycles; no IDLE between instructions.
- mem_ready held low 5 cycles with TIMEOUT=16: S2 lasts 6 cycles, then S3. With mem_ready never high, err=1 after 16 S2 cycles, step=0, and run cannot restart until reset.
- halt raised in S2: instruction completes through S7, then step=0. Lowering halt restarts at S1 on the next edge.
- reset_n pulsed low during S3: all outputs immediately go to reset values. iar_rst stays 1 for 2 edges after release; first S1 occurs no earlier than the third edge.
- instr_cnt preloaded via force to 16'hFFFF: the next instruction end wraps it to 0.
